pn_eval_param: RTL and testbench

- Parametrised single-clock Polish-notation expression evaluator; successor to the fixed 3-bit PN datapath.
- Accepts one token per cycle (operand or operator) in prefix or postfix order and returns one signed result.
- Adds generic operand/result widths, bounded token buffer and evaluation stack, and an explicit error flag for malformed expressions.
- Sits behind the input synchroniser; result feeds the output handshake stage.

---
 rtl/pn_pkg.sv | 25 ++
 rtl/pn_alu.sv | 67 ++++++
 rtl/pn_eval_param.sv | 264 ++++++++++++++++++++++++++
 tb/tb_pn_eval_param.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pn_pkg.sv
// -----------------------------------------------------------------------------
// pn_pkg
// Shared definitions for the Polish-notation evaluator:
//   - operator codes carried in in[1:0] of an operator token
//   - expression order selector sampled on the first token
//   - evaluator FSM state type
// -----------------------------------------------------------------------------
package pn_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;  // a + b
    localparam logic [1:0] OP_SUB = 2'b01;  // a - b
    localparam logic [1:0] OP_MUL = 2'b10;  // a * b
    localparam logic [1:0] OP_ABS = 2'b11;  // |a - b|

    localparam logic MODE_PREFIX  = 1'b0;
    localparam logic MODE_POSTFIX = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EVAL = 2'd2,
        ST_OUT  = 2'd3
    } pn_state_e;

endpackage

// File: rtl/pn_alu.sv
// -----------------------------------------------------------------------------
// pn_alu
// Combinational signed ALU for the PN evaluator.
//   a, b : signed OUT_W operands (a is the left-hand operand)
//   op   : operator code (OP_ADD/OP_SUB/OP_MUL/OP_ABS)
//   res  : signed OUT_W result
// Build option: define SAT_EN to clamp every result to the signed OUT_W range;
// without it results wrap modulo 2^OUT_W.
// -----------------------------------------------------------------------------
module pn_alu
    import pn_pkg::*;
#(
    parameter int unsigned OUT_W = 64
) (
    input  logic signed [OUT_W-1:0] a,
    input  logic signed [OUT_W-1:0] b,
    input  logic        [1:0]       op,
    output logic signed [OUT_W-1:0] res
);

`ifdef SAT_EN
    // Wide enough that a full product of two OUT_W values cannot overflow.
    localparam int unsigned WW = 2 * OUT_W + 2;
    localparam logic signed [WW-1:0] MAX_V = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WW-1:0] MIN_V = {{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [WW-1:0] wa;
    logic signed [WW-1:0] wb;
    logic signed [WW-1:0] diff;
    logic signed [WW-1:0] wide;

    always_comb begin
        wa   = {{(WW-OUT_W){a[OUT_W-1]}}, a};
        wb   = {{(WW-OUT_W){b[OUT_W-1]}}, b};
        diff = wa - wb;
        unique case (op)
            OP_ADD:  wide = wa + wb;
            OP_SUB:  wide = diff;
            OP_MUL:  wide = wa * wb;
            OP_ABS:  wide = diff[WW-1] ? -diff : diff;
            default: wide = '0;
        endcase
        if (wide > MAX_V) begin
            res = MAX_V[OUT_W-1:0];
        end else if (wide < MIN_V) begin
            res = MIN_V[OUT_W-1:0];
        end else begin
            res = wide[OUT_W-1:0];
        end
    end
`else
    logic signed [OUT_W-1:0] diff;

    always_comb begin
        diff = a - b;
        unique case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = diff;
            OP_MUL:  res = a * b;
            // Magnitude of the wrapped difference.
            OP_ABS:  res = diff[OUT_W-1] ? -diff : diff;
            default: res = '0;
        endcase
    end
`endif

endmodule

// File: rtl/pn_eval_param.sv
// -----------------------------------------------------------------------------
// pn_eval_param
// Single-clock Polish-notation expression evaluator, one token per cycle.
// Postfix tokens are evaluated on arrival; prefix tokens are buffered and then
// evaluated last-to-first, one per cycle.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   in_valid          : token strobe, contiguous for a whole expression
//   mode              : 0 prefix / 1 postfix, sampled on the first token only
//   operator          : 1 = operator token (code in in[1:0]), 0 = operand
//   in [DATA_W-1:0]   : unsigned operand or operator code
//   out_valid         : one-cycle result strobe
//   out [OUT_W-1:0]   : signed result, 0 whenever out_valid is low
//   out_err           : malformed expression, qualified by out_valid
// Build option: SAT_EN selects saturating arithmetic inside pn_alu.
// -----------------------------------------------------------------------------
module pn_eval_param
    import pn_pkg::*;
#(
    parameter int unsigned DATA_W      = 3,
    parameter int unsigned OUT_W       = 64,
    parameter int unsigned MAX_TOK     = 31,
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              mode,
    input  logic              operator,
    input  logic [DATA_W-1:0] in,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out,
    output logic              out_err
);

    localparam int unsigned SPW  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(MAX_TOK + 1);
    localparam int unsigned BIW  = (MAX_TOK > 1) ? $clog2(MAX_TOK) : 1;

    // State
    pn_state_e            state_q, state_d;
    logic                 mode_q, mode_d;
    logic [SPW-1:0]       sp_q, sp_d;        // number of live stack entries
    logic                 err_q, err_d;      // sticky malformed-expression flag
    logic [CNTW-1:0]      cnt_q, cnt_d;      // tokens accepted, saturates at MAX_TOK
    logic [BIW-1:0]       rd_q, rd_d;        // prefix read pointer during EVAL
    logic                 out_valid_q, out_valid_d;
    logic [OUT_W-1:0]     out_q, out_d;
    logic                 out_err_q, out_err_d;

    logic [OUT_W-1:0]     stack_q [STACK_DEPTH];
    logic [DATA_W:0]      tok_buf_q [MAX_TOK];

    // Token datapath
    logic                 cur_mode;
    logic                 tok_is_op;
    logic [DATA_W-1:0]    tok_val;
    logic                 apply;
    logic                 buf_we;
    logic [BIW-1:0]       buf_idx;
    logic [IDXW-1:0]      top_idx;
    logic [IDXW-1:0]      nxt_idx;
    logic [OUT_W-1:0]     alu_a;
    logic [OUT_W-1:0]     alu_b;
    logic [OUT_W-1:0]     alu_res;

    // Stack effect of the applied token
    logic                 push_en;
    logic [IDXW-1:0]      push_idx;
    logic [OUT_W-1:0]     push_val;
    logic [SPW-1:0]       st_sp;
    logic                 st_err;
    logic                 fin_err;

    // Select the token to apply this cycle and decide whether it is evaluated
    // or buffered.
    always_comb begin
        cur_mode  = (state_q == ST_IDLE) ? mode : mode_q;
        tok_is_op = operator;
        tok_val   = in;
        apply     = 1'b0;
        buf_we    = 1'b0;
        buf_idx   = BIW'(cnt_q);

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (mode == MODE_POSTFIX) begin
                        apply = 1'b1;
                    end else begin
                        buf_we = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (in_valid && (cnt_q != CNTW'(MAX_TOK)) && !err_q) begin
                    if (mode_q == MODE_POSTFIX) begin
                        apply = 1'b1;
                    end else begin
                        buf_we = 1'b1;
                    end
                end
            end
            ST_EVAL: begin
                {tok_is_op, tok_val} = tok_buf_q[rd_q];
                apply = !err_q;
            end
            default: ;
        endcase

        top_idx = IDXW'(sp_q - SPW'(1));
        nxt_idx = IDXW'(sp_q - SPW'(2));
        // Postfix: deeper entry is the left operand. Prefix (scanned backwards):
        // the top is the left operand.
        if (cur_mode == MODE_POSTFIX) begin
            alu_a = stack_q[nxt_idx];
            alu_b = stack_q[top_idx];
        end else begin
            alu_a = stack_q[top_idx];
            alu_b = stack_q[nxt_idx];
        end
    end

    pn_alu #(
        .OUT_W (OUT_W)
    ) u_alu (
        .a   (alu_a),
        .b   (alu_b),
        .op  (tok_val[1:0]),
        .res (alu_res)
    );

    // Stack update for an applied token: push operand, or pop two and push result.
    always_comb begin
        push_en  = 1'b0;
        push_idx = '0;
        push_val = alu_res;
        st_sp    = sp_q;
        st_err   = 1'b0;
        if (apply) begin
            if (tok_is_op) begin
                if (sp_q < SPW'(2)) begin
                    st_err = 1'b1;
                end else begin
                    push_en  = 1'b1;
                    push_idx = nxt_idx;
                    push_val = alu_res;
                    st_sp    = sp_q - SPW'(1);
                end
            end else begin
                if (sp_q == SPW'(STACK_DEPTH)) begin
                    st_err = 1'b1;
                end else begin
                    push_en  = 1'b1;
                    push_idx = IDXW'(sp_q);
                    push_val = OUT_W'(tok_val);
                    st_sp    = sp_q + SPW'(1);
                end
            end
        end
    end

    // FSM and result formation.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        sp_d        = st_sp;
        err_d       = err_q | st_err;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        out_valid_d = 1'b0;
        out_d       = '0;
        out_err_d   = 1'b0;
        fin_err     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_LOAD;
                    mode_d  = mode;
                    cnt_d   = CNTW'(1);
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    if (cnt_q == CNTW'(MAX_TOK)) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end else if (mode_q == MODE_POSTFIX) begin
                    fin_err     = err_q | (sp_q != SPW'(1));
                    state_d     = ST_OUT;
                    out_valid_d = 1'b1;
                    out_err_d   = fin_err;
                    out_d       = fin_err ? '0 : stack_q[0];
                end else begin
                    state_d = ST_EVAL;
                    rd_d    = BIW'(cnt_q - CNTW'(1));
                end
            end
            ST_EVAL: begin
                if (rd_q == '0) begin
                    // With a clean final push to depth 1, push_val is the result.
                    fin_err     = err_d | (st_sp != SPW'(1));
                    state_d     = ST_OUT;
                    out_valid_d = 1'b1;
                    out_err_d   = fin_err;
                    out_d       = fin_err ? '0 : push_val;
                end else begin
                    rd_d = rd_q - BIW'(1);
                end
            end
            ST_OUT: begin
                state_d = ST_IDLE;
                sp_d    = '0;
                err_d   = 1'b0;
                cnt_d   = '0;
                rd_d    = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_PREFIX;
            sp_q        <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            rd_q        <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            sp_q        <= sp_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            out_err_q   <= out_err_d;
        end
    end

    // Storage arrays carry no reset; pointers decide what is live.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= push_val;
        end
        if (buf_we) begin
            tok_buf_q[buf_idx] <= {tok_is_op, tok_val};
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_pn_eval_param.sv
// -----------------------------------------------------------------------------
// tb_pn_eval_param
// Directed bench for pn_eval_param: a default instance (OUT_W=64) and a narrow
// instance (OUT_W=8) share the token stream. Expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_pn_eval_param;
    import pn_pkg::*;

    localparam logic [3:0] T_ADD = 4'b1000;
    localparam logic [3:0] T_SUB = 4'b1001;
    localparam logic [3:0] T_MUL = 4'b1010;
    localparam logic [3:0] T_ABS = 4'b1011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        mode;
    logic        operator;
    logic [2:0]  in_tok;
    logic        out_valid;
    logic [63:0] out;
    logic        out_err;
    logic        out_valid8;
    logic [7:0]  out8;
    logic        out_err8;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [3:0]  tokq [$];
    int          got_lat;
    logic [63:0] got_out;
    logic [7:0]  got_out8;
    logic        got_err;
    logic        got_zero_ok;
    logic        got_width_ok;

    always #5 clk = ~clk;

    pn_eval_param u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .mode      (mode),
        .operator  (operator),
        .in        (in_tok),
        .out_valid (out_valid),
        .out       (out),
        .out_err   (out_err)
    );

    pn_eval_param #(
        .OUT_W (8)
    ) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .mode      (mode),
        .operator  (operator),
        .in        (in_tok),
        .out_valid (out_valid8),
        .out       (out8),
        .out_err   (out_err8)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives tokq, then drops in_valid; returns at the negedge of the first
    // cycle with in_valid low. mode is inverted after the first token.
    task automatic drive_tokens(input logic m);
        for (int i = 0; i < tokq.size(); i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            mode     = (i == 0) ? m : ~m;
            operator = tokq[i][3];
            in_tok   = tokq[i][2:0];
        end
        @(negedge clk);
        in_valid = 1'b0;
        mode     = 1'b0;
        operator = 1'b0;
        in_tok   = '0;
    endtask

    task automatic wait_result(input int budget);
        got_lat      = -1;
        got_out      = '0;
        got_out8     = '0;
        got_err      = 1'b0;
        got_width_ok = 1'b0;
        got_zero_ok  = !out_valid && (out == 64'd0) && !out_err;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (out_valid) begin
                got_lat  = k;
                got_out  = out;
                got_out8 = out8;
                got_err  = out_err;
                break;
            end else if ((out != 64'd0) || out_err) begin
                got_zero_ok = 1'b0;
            end
        end
        if (got_lat > 0) begin
            @(negedge clk);
            got_width_ok = !out_valid && (out == 64'd0) && !out_err;
        end
    endtask

    task automatic run_expr(input string tag, input logic m, input logic [63:0] exp_out,
                            input logic exp_err, input int exp_lat);
        drive_tokens(m);
        wait_result(exp_lat + 40);
        check_eq({tag, "_out"}, got_out, exp_out);
        check_eq({tag, "_err"}, 64'(got_err), 64'(exp_err));
        check_eq({tag, "_lat"}, 64'(got_lat), 64'(exp_lat));
        check_eq({tag, "_width"}, 64'(got_width_ok), 64'd1);
        check_eq({tag, "_idle0"}, 64'(got_zero_ok), 64'd1);
    endtask

    initial begin
        logic seen;
        logic zero_ok;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        mode     = 1'b0;
        operator = 1'b0;
        in_tok   = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out", out, 64'd0);
        check_eq("rst_err", 64'(out_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 3 4 + 2 * = 14
        tokq = '{4'h3, 4'h4, T_ADD, 4'h2, T_MUL};
        run_expr("pf_basic", MODE_POSTFIX, 64'd14, 1'b0, 1);

        // - 7 * 2 3 = 7 - (2*3) = 1, five tokens
        tokq = '{T_SUB, 4'h7, T_MUL, 4'h2, 4'h3};
        run_expr("pre_basic", MODE_PREFIX, 64'd1, 1'b0, 6);

        tokq = '{4'h2, 4'h7, T_ABS};
        run_expr("pf_abs", MODE_POSTFIX, 64'd5, 1'b0, 1);

        tokq = '{4'h2, 4'h7, T_SUB};
        run_expr("pf_sub", MODE_POSTFIX, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1);

        // Prefix "- 2 7": left operand is 2
        tokq = '{T_SUB, 4'h2, 4'h7};
        run_expr("pre_sub", MODE_PREFIX, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 4);

        tokq = '{4'h1, T_ADD};
        run_expr("err_under", MODE_POSTFIX, 64'd0, 1'b1, 1);

        tokq = '{4'h1, 4'h2};
        run_expr("err_depth", MODE_POSTFIX, 64'd0, 1'b1, 1);

        // 33 tokens: 1 (1 +)x16; stack never exceeds 2, only the count overflows
        tokq = {};
        tokq.push_back(4'h1);
        repeat (16) begin
            tokq.push_back(4'h1);
            tokq.push_back(T_ADD);
        end
        run_expr("err_count", MODE_POSTFIX, 64'd0, 1'b1, 1);

        // 7^4 = 2401; the 8-bit instance wraps to 97 or clamps to 127
        tokq = '{4'h7, 4'h7, T_MUL, 4'h7, T_MUL, 4'h7, T_MUL};
        run_expr("pf_pow", MODE_POSTFIX, 64'd2401, 1'b0, 1);
`ifdef SAT_EN
        check_eq("w8_pow", 64'(got_out8), 64'd127);
`else
        check_eq("w8_pow", 64'(got_out8), 64'd97);
`endif

        // Reset during prefix EVAL aborts the expression silently
        tokq = '{T_SUB, 4'h7, T_MUL, 4'h2, 4'h3};
        drive_tokens(MODE_PREFIX);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        seen    = 1'b0;
        zero_ok = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            if ((out != 64'd0) || out_err) zero_ok = 1'b0;
        end
        check_eq("rst_mid_valid", 64'(seen), 64'd0);
        check_eq("rst_mid_out0", 64'(zero_ok), 64'd1);

        tokq = '{4'h1, 4'h1, T_ADD};
        run_expr("post_rst", MODE_POSTFIX, 64'd2, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
